// File: rtl/symbol_read_scheduler.sv
// Read-side scheduler for the I/Q CDC FIFO: pops one symbol per period, inserts fillers on underflow.
// Define SYM_SCHED_HOLD_LAST_EN to make fillers repeat the last real symbol instead of zeros.
module symbol_read_scheduler #(
  parameter int DATA_W   = 4,
  parameter int SPS_MIN  = 2,
  parameter int UF_LIMIT = 8,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [3:0]            sample_rate,
  input  logic                  fifo_empty,
  input  logic [2*DATA_W-1:0]   fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic [DATA_W-1:0]     data_in_i,
  output logic [DATA_W-1:0]     data_in_q,
  output logic                  new_symbol,
  output logic                  running,
  output logic                  underflow,
  output logic [CNT_W-1:0]      underflow_count,
  output logic                  uf_abort
);

  localparam int UFC_W = $clog2(UF_LIMIT + 1);
  localparam logic [3:0] SPS_MIN_V = 4'(SPS_MIN);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               pend_q, pend_d;
  logic               pend_uf_q, pend_uf_d;
  logic [UFC_W-1:0]   consec_q, consec_d;
  logic [DATA_W-1:0]  sym_i_q, sym_i_d;
  logic [DATA_W-1:0]  sym_q_q, sym_q_d;
  logic               strobe_q, strobe_d;
  logic               uf_q, uf_d;
  logic               abort_q, abort_d;
  logic [CNT_W-1:0]   uf_cnt_q, uf_cnt_d;
  logic               slot;
  logic               abort_hit;
  logic [3:0]         sps;

  assign sps = (sample_rate < SPS_MIN_V) ? SPS_MIN_V : sample_rate;

  always_comb begin
    slot      = (state_q == S_RUN) && (cnt_q == 4'd0) && enable && !rst;
    abort_hit = pend_q && pend_uf_q && (consec_q == UFC_W'(UF_LIMIT - 1));

    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = slot;
    pend_uf_d = slot && fifo_empty;
    consec_d  = consec_q;
    sym_i_d   = sym_i_q;
    sym_q_d   = sym_q_q;
    strobe_d  = pend_q;
    uf_d      = pend_q && pend_uf_q;
    abort_d   = abort_hit;
    uf_cnt_d  = uf_cnt_q;

    case (state_q)
      S_IDLE: if (enable) state_d = S_FILL;
      S_FILL: begin
        if (!enable)          state_d = S_IDLE;
        else if (!fifo_empty) state_d = S_RUN;
      end
      S_RUN: begin
        // An in-flight read finishes its strobe before leaving RUN on disable.
        if (abort_hit)                state_d = S_FILL;
        else if (!enable && !pend_q)  state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Counter idles at 0 outside RUN so the first RUN cycle is a slot.
    if (state_q != S_RUN)     cnt_d = 4'd0;
    else if (cnt_q != 4'd0)   cnt_d = cnt_q - 4'd1;
    else if (slot)            cnt_d = sps - 4'd1;

    if (pend_q) begin
      if (pend_uf_q) begin
        consec_d = abort_hit ? '0 : consec_q + 1'b1;
        uf_cnt_d = (&uf_cnt_q) ? uf_cnt_q : uf_cnt_q + 1'b1;
`ifndef SYM_SCHED_HOLD_LAST_EN
        sym_i_d  = '0;
        sym_q_d  = '0;
`endif
      end else begin
        consec_d = '0;
        sym_i_d  = fifo_rd_data[2*DATA_W-1:DATA_W];
        sym_q_d  = fifo_rd_data[DATA_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      pend_uf_q <= 1'b0;
      consec_q  <= '0;
      sym_i_q   <= '0;
      sym_q_q   <= '0;
      strobe_q  <= 1'b0;
      uf_q      <= 1'b0;
      abort_q   <= 1'b0;
      uf_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pend_uf_q <= pend_uf_d;
      consec_q  <= consec_d;
      sym_i_q   <= sym_i_d;
      sym_q_q   <= sym_q_d;
      strobe_q  <= strobe_d;
      uf_q      <= uf_d;
      abort_q   <= abort_d;
      uf_cnt_q  <= uf_cnt_d;
    end
  end

  assign fifo_rd_en      = slot && !fifo_empty;
  assign running         = (state_q == S_RUN);
  assign data_in_i       = sym_i_q;
  assign data_in_q       = sym_q_q;
  assign new_symbol      = strobe_q;
  assign underflow       = uf_q;
  assign underflow_count = uf_cnt_q;
  assign uf_abort        = abort_q;

endmodule
